// File: rtl/cam_alloc_ctrl_if.sv
// Request/response and CAM-side bundle of the CAM allocation controller.
// The slave modport is the controller; master is the surrounding environment.
interface cam_alloc_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [DATA_WIDTH-1:0] req_key;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [1:0]            rsp_status;
  logic [ADDR_WIDTH:0]   occupancy;
  logic                  full;
  logic [ADDR_WIDTH-1:0] cam_write_addr;
  logic [DATA_WIDTH-1:0] cam_write_data;
  logic                  cam_write_delete;
  logic                  cam_write_enable;
  logic                  cam_write_busy;
  logic [DATA_WIDTH-1:0] cam_compare_data;
  logic                  cam_match;
  logic [ADDR_WIDTH-1:0] cam_match_addr;

  modport slave (
    input  req_valid, req_op, req_key, rsp_ready,
    input  cam_write_busy, cam_match, cam_match_addr,
    output req_ready, rsp_valid, rsp_addr, rsp_status, occupancy, full,
    output cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
    output cam_compare_data
  );

  modport master (
    output req_valid, req_op, req_key, rsp_ready,
    output cam_write_busy, cam_match, cam_match_addr,
    input  req_ready, rsp_valid, rsp_addr, rsp_status, occupancy, full,
    input  cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
    input  cam_compare_data
  );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// Insert/delete front end for the shift-register CAM: looks the key up, picks a
// free row, drives the CAM write handshake and returns one response per request.
module cam_alloc_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            rst,
  cam_alloc_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_DUP  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_MISS = 2'd3;

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, EVAL, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic [DEPTH-1:0]      valid_map;
  logic [ADDR_WIDTH:0]   occ;
  logic [ADDR_WIDTH:0]   occ_next;
  logic                  full_r;
  logic                  op_r;
  logic [DATA_WIDTH-1:0] key_r;
  logic                  rsp_valid_r;
  logic [ADDR_WIDTH-1:0] rsp_addr_r;
  logic [1:0]            rsp_status_r;
  logic                  we_r;
  logic                  wdel_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [ADDR_WIDTH-1:0] free_idx;

  // Lowest-index empty row; scanning downward lets the last hit win.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_map[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  assign occ_next = op_r ? (occ - 1'b1) : (occ + 1'b1);

  // The write address register doubles as the target row through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      valid_map    <= '0;
      occ          <= '0;
      full_r       <= 1'b0;
      op_r         <= 1'b0;
      key_r        <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_addr_r   <= '0;
      rsp_status_r <= ST_OK;
      we_r         <= 1'b0;
      wdel_r       <= 1'b0;
      waddr_r      <= '0;
      wdata_r      <= '0;
    end else begin
      we_r <= 1'b0;
      case (state)
        INIT: begin
          if (!bus.cam_write_busy) state <= IDLE;
        end
        IDLE: begin
          if (bus.req_valid && !bus.cam_write_busy) begin
            op_r  <= bus.req_op;
            key_r <= bus.req_key;
            state <= LOOKUP;
          end
        end
        LOOKUP: state <= EVAL;
        EVAL: begin
          if (!op_r) begin
            if (bus.cam_match) begin
              rsp_status_r <= ST_DUP;
              rsp_addr_r   <= bus.cam_match_addr;
              rsp_valid_r  <= 1'b1;
              state        <= RESP;
            end else if (full_r) begin
              rsp_status_r <= ST_FULL;
              rsp_addr_r   <= '0;
              rsp_valid_r  <= 1'b1;
              state        <= RESP;
            end else begin
              we_r    <= 1'b1;
              wdel_r  <= 1'b0;
              waddr_r <= free_idx;
              wdata_r <= key_r;
              state   <= ISSUE;
            end
          end else begin
            if (bus.cam_match) begin
              we_r    <= 1'b1;
              wdel_r  <= 1'b1;
              waddr_r <= bus.cam_match_addr;
              wdata_r <= key_r;
              state   <= ISSUE;
            end else begin
              rsp_status_r <= ST_MISS;
              rsp_addr_r   <= '0;
              rsp_valid_r  <= 1'b1;
              state        <= RESP;
            end
          end
        end
        ISSUE: begin
          valid_map[waddr_r] <= !op_r;
          occ                <= occ_next;
          full_r             <= (occ_next == (ADDR_WIDTH + 1)'(DEPTH));
          rsp_status_r       <= ST_OK;
          rsp_addr_r         <= waddr_r;
          state              <= WAIT;
        end
        WAIT: begin
          if (!bus.cam_write_busy) begin
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.req_ready        = (state == IDLE) && !bus.cam_write_busy;
  assign bus.rsp_valid        = rsp_valid_r;
  assign bus.rsp_addr         = rsp_addr_r;
  assign bus.rsp_status       = rsp_status_r;
  assign bus.occupancy        = occ;
  assign bus.full             = full_r;
  assign bus.cam_write_addr   = waddr_r;
  assign bus.cam_write_data   = wdata_r;
  assign bus.cam_write_delete = wdel_r;
  assign bus.cam_write_enable = we_r;
  assign bus.cam_compare_data = key_r;
endmodule

// File: doc/cam_alloc_ctrl.md
# cam_alloc_ctrl

Request-side controller that sits directly upstream of the shift-register CAM and owns both its write port and its compare port. Accepts insert/delete requests keyed by data value, checks for an existing entry, allocates a free row for new keys, drives the CAM write handshake, and returns one response per request with the row address and a status. Keeps a valid bitmap and occupancy count so software never manages CAM addresses directly.

## Interface
- DATA_WIDTH, 64, key width; must equal the CAM's DATA_WIDTH
- ADDR_WIDTH, 5, CAM address width; 2**ADDR_WIDTH rows
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_op  in  1  0 = insert, 1 = delete
- req_key  in  DATA_WIDTH  key
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_addr  out  ADDR_WIDTH  row address (0 for FULL/MISS)
- rsp_status  out  2  0 OK, 1 DUP, 2 FULL, 3 MISS
- occupancy  out  ADDR_WIDTH+1  number of valid rows
- full  out  1  occupancy == 2**ADDR_WIDTH
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr
- cam_write_data  out  DATA_WIDTH  to CAM write_data
- cam_write_delete  out  1  to CAM write_delete
- cam_write_enable  out  1  to CAM write_enable; single-cycle pulse
- cam_write_busy  in  1  from CAM write_busy
- cam_compare_data  out  DATA_WIDTH  to CAM compare_data; always = latched key
- cam_match  in  1  from CAM match
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr

## Operation
- States: INIT, IDLE, LOOKUP, EVAL, ISSUE, WAIT, RESP.
- INIT: entered on reset; valid bitmap, occupancy, key register cleared; exits to IDLE first cycle cam_write_busy = 0 (CAM self-clear).
- IDLE: req_ready = 1 iff state IDLE and cam_write_busy = 0. On handshake latch req_op, req_key -> LOOKUP.
- LOOKUP: one cycle; CAM registers match of latched key. -> EVAL.
- EVAL (cam_match/cam_match_addr valid):
  - insert, match: status DUP, addr = cam_match_addr -> RESP, no write.
  - insert, no match, full: status FULL, addr 0 -> RESP.
  - insert, no match, not full: target = lowest-index row with valid bit 0 -> ISSUE (delete = 0).
  - delete, match: target = cam_match_addr -> ISSUE (delete = 1).
  - delete, no match: status MISS, addr 0 -> RESP.
- ISSUE: cam_write_enable = 1 one cycle with addr/data/delete; set (insert) or clear (delete) valid bit, occupancy +/-1, status OK, addr = target -> WAIT.
- WAIT: stay while cam_write_busy = 1; -> RESP on first cycle it is 0.
- RESP: rsp_valid = 1, rsp_addr/rsp_status stable; on rsp_ready -> IDLE.
- Multiple CAM hits never arise (duplicates rejected); if they do, lowest address (cam_match_addr) is used.
- cam_write_* outputs hold last values when enable is 0; only enable is qualified.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_addr 0, rsp_status 0, occupancy 0, full 0, cam_write_enable 0, cam_write_delete 0, cam_write_addr 0, cam_write_data 0, cam_compare_data 0.
- Handshake in cycle T: LOOKUP T+1, EVAL T+2; non-writing responses rsp_valid at T+3.
- Writing requests: cam_write_enable at T+3; CAM busy high from T+4; rsp_valid the cycle after busy is first sampled low (T+21 with a 16-step CAM write).
- occupancy/full update the cycle after ISSUE.
- rsp_valid with rsp_ready low: hold indefinitely, no new request accepted.
- req_valid while busy: req_ready stays 0; no request dropped or duplicated.
- rst in any state (incl. WAIT mid-write): next cycle INIT, all outputs to reset values, pending response discarded, bitmap cleared (CAM is reset by the same rst).
- Free-slot search and bitmap wrap: after freeing row k, next insert allocates lowest free row, which may be below previously allocated rows.

## Test plan
- Reset, hold rst 3 cycles -> req_ready 0 until CAM busy falls, then 1; occupancy 0, full 0.
- Insert 0xABCD -> cam_write_enable one pulse, addr 0, delete 0; rsp OK addr 0 at busy-fall+1; occupancy 1.
- Insert 0xABCD again -> no write pulse, rsp DUP addr 0 at T+3.
- Fill all 32 rows with keys 1..32, insert 33 -> full 1, rsp FULL addr 0, no write.
- Delete key 5 (row 4) -> write pulse delete 1 addr 4, rsp OK addr 4, occupancy 31; insert 99 -> allocated row 4; delete 1234 -> rsp MISS.
- Assert rst during WAIT of an insert -> no rsp_valid, INIT, occupancy 0; subsequent insert gets addr 0.
